// File: rtl/usb_dpdm_xcvr.sv
// Half-duplex DP/DM line transceiver: bit-count-driven TX serialiser with SE0/J EOP,
// and an RX front end that detects start K, validates EOP and flags SE1/babble/long-SE0.
module usb_dpdm_xcvr #(
  parameter int unsigned MAX_BITS    = 128,
  parameter int unsigned EOP_SE0     = 2,
  parameter int unsigned EOP_J       = 1,
  parameter int unsigned EOP_SE0_MAX = 8,
  localparam int unsigned CW         = $clog2(MAX_BITS + 1)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          tx_start,
  input  logic [CW-1:0] tx_len,
  input  logic          tx_bit,
  output logic          tx_bit_req,
  output logic          tx_busy,
  output logic          tx_done,
  output logic          dp_w,
  output logic          dm_w,
  input  logic          rx_en,
  input  logic          dp_r,
  input  logic          dm_r,
  output logic          rx_bit,
  output logic          rx_valid,
  output logic          rx_done,
  output logic          rx_err,
  output logic [CW-1:0] rx_count
);

  localparam int unsigned TMAX = (MAX_BITS > EOP_SE0)
                               ? ((MAX_BITS > EOP_J) ? MAX_BITS : EOP_J)
                               : ((EOP_SE0 > EOP_J) ? EOP_SE0 : EOP_J);
  localparam int unsigned TCW  = $clog2(TMAX + 1);
  localparam int unsigned SW   = $clog2(EOP_SE0_MAX + 2);

  typedef enum logic [1:0] {T_IDLE, T_DATA, T_SE0, T_EOPJ} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_DATA, R_EOP} rx_state_e;

  tx_state_e          tx_state_q, tx_state_d;
  logic [TCW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [CW-1:0]      tx_len_q, tx_len_d;

  rx_state_e          rx_state_q, rx_state_d;
  logic [CW-1:0]      rx_count_q, rx_count_d;
  logic [SW-1:0]      se0_cnt_q, se0_cnt_d;

  logic               rx_act;
  logic               line_j, line_k, line_se0;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_len_q   <= '0;
      rx_state_q <= R_IDLE;
      rx_count_q <= '0;
      se0_cnt_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_len_q   <= tx_len_d;
      rx_state_q <= rx_state_d;
      rx_count_q <= rx_count_d;
      se0_cnt_q  <= se0_cnt_d;
    end
  end

  assign tx_busy = (tx_state_q != T_IDLE);

  // TX: data bits pass straight to the pads; the line idles at J.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_len_d   = tx_len_q;
    tx_bit_req = 1'b0;
    tx_done    = 1'b0;
    dp_w       = 1'b1;
    dm_w       = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (tx_start) begin
          tx_len_d   = (32'(tx_len) > MAX_BITS) ? CW'(MAX_BITS) : tx_len;
          tx_cnt_d   = '0;
          tx_state_d = (tx_len == '0) ? T_SE0 : T_DATA;
        end
      end
      T_DATA: begin
        tx_bit_req = 1'b1;
        dp_w       = tx_bit;
        dm_w       = ~tx_bit;
        if (32'(tx_cnt_q) + 32'd1 >= 32'(tx_len_q)) begin
          tx_cnt_d   = '0;
          tx_state_d = T_SE0;
        end else begin
          tx_cnt_d = tx_cnt_q + TCW'(1);
        end
      end
      T_SE0: begin
        dp_w = 1'b0;
        dm_w = 1'b0;
        if (32'(tx_cnt_q) + 32'd1 >= EOP_SE0) begin
          tx_cnt_d   = '0;
          tx_state_d = T_EOPJ;
        end else begin
          tx_cnt_d = tx_cnt_q + TCW'(1);
        end
      end
      T_EOPJ: begin
        if (32'(tx_cnt_q) + 32'd1 >= EOP_J) begin
          tx_done    = 1'b1;
          tx_cnt_d   = '0;
          tx_state_d = T_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + TCW'(1);
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  assign rx_act   = rx_en & ~tx_busy;
  assign line_j   = dp_r & ~dm_r;
  assign line_k   = ~dp_r & dm_r;
  assign line_se0 = ~dp_r & ~dm_r;
  assign rx_bit   = dp_r;
  assign rx_count = rx_count_q;

  // RX: losing the gate silently abandons the packet, keeping rx_count.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_count_d = rx_count_q;
    se0_cnt_d  = se0_cnt_q;
    rx_valid   = 1'b0;
    rx_done    = 1'b0;
    rx_err     = 1'b0;
    if (!rx_act) begin
      rx_state_d = R_IDLE;
    end else begin
      case (rx_state_q)
        R_IDLE: begin
          if (line_k) begin
            rx_valid   = 1'b1;
            rx_count_d = CW'(1);
            rx_state_d = R_DATA;
          end
        end
        R_DATA: begin
          if (line_j || line_k) begin
            if (rx_count_q == CW'(MAX_BITS)) begin
              rx_err     = 1'b1;
              rx_state_d = R_IDLE;
            end else begin
              rx_valid   = 1'b1;
              rx_count_d = rx_count_q + CW'(1);
            end
          end else if (line_se0) begin
            se0_cnt_d  = SW'(1);
            rx_state_d = R_EOP;
          end else begin
            rx_err     = 1'b1;
            rx_state_d = R_IDLE;
          end
        end
        R_EOP: begin
          if (line_se0) begin
            if (32'(se0_cnt_q) + 32'd1 > EOP_SE0_MAX) begin
              rx_err     = 1'b1;
              rx_state_d = R_IDLE;
            end else begin
              se0_cnt_d = se0_cnt_q + SW'(1);
            end
          end else if (line_j && (32'(se0_cnt_q) >= EOP_SE0)) begin
            rx_done    = 1'b1;
            rx_state_d = R_IDLE;
          end else begin
            rx_err     = 1'b1;
            rx_state_d = R_IDLE;
          end
        end
        default: rx_state_d = R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_dpdm_xcvr.sv
// Directed bench for usb_dpdm_xcvr: hand-sequenced TX scenarios plus a table of RX line vectors.
module tb_usb_dpdm_xcvr;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          tx_start;
  logic [CW-1:0] tx_len;
  logic          tx_bit;
  logic          tx_bit_req, tx_busy, tx_done, dp_w, dm_w;
  logic          rx_en, dp_r, dm_r;
  logic          rx_bit, rx_valid, rx_done, rx_err;
  logic [CW-1:0] rx_count;

  int checks = 0;
  int errors = 0;

  usb_dpdm_xcvr #(.MAX_BITS(128), .EOP_SE0(2), .EOP_J(1), .EOP_SE0_MAX(8)) dut (
    .clk(clk), .rst_b(rst_b),
    .tx_start(tx_start), .tx_len(tx_len), .tx_bit(tx_bit),
    .tx_bit_req(tx_bit_req), .tx_busy(tx_busy), .tx_done(tx_done),
    .dp_w(dp_w), .dm_w(dm_w),
    .rx_en(rx_en), .dp_r(dp_r), .dm_r(dm_r),
    .rx_bit(rx_bit), .rx_valid(rx_valid), .rx_done(rx_done), .rx_err(rx_err),
    .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic dp, dm, en;
    logic v, dn, er;
    int   cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic [1:0] ln, input logic en, input logic v,
                              input logic dn, input logic er, input int cnt);
    vec_t e;
    e.dp = ln[1]; e.dm = ln[0]; e.en = en;
    e.v = v; e.dn = dn; e.er = er; e.cnt = cnt;
    vecs.push_back(e);
  endfunction

  function automatic logic [4:0] tx_outs();
    return {tx_bit_req, tx_busy, tx_done, dp_w, dm_w};
  endfunction

  localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LS0 = 2'b00, LS1 = 2'b11;

  initial begin
    int c;
    int reqs;
    int done_at;
    logic b;

    // RX vector table: {line, rx_en} -> {rx_valid, rx_done, rx_err}, rx_count before the edge
    add(LJ, 1, 0, 0, 0, 0);
    add(LK, 1, 1, 0, 0, 0);
    c = 1;
    for (int i = 1; i <= 15; i++) begin
      add((i % 2) ? LJ : LK, 1, 1, 0, 0, c);
      c++;
    end
    add(LS0, 1, 0, 0, 0, 16);
    add(LS0, 1, 0, 0, 0, 16);
    add(LJ,  1, 0, 1, 0, 16);
    add(LJ,  1, 0, 0, 0, 16);
    // short EOP
    add(LK,  1, 1, 0, 0, 16);
    add(LS0, 1, 0, 0, 0, 1);
    add(LK,  1, 0, 0, 1, 1);
    add(LJ,  1, 0, 0, 0, 1);
    // SE0 x9 aborts on the ninth
    add(LK,  1, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) add(LS0, 1, 0, 0, 0, 1);
    add(LS0, 1, 0, 0, 1, 1);
    add(LS0, 1, 0, 0, 0, 1);
    add(LJ,  1, 0, 0, 0, 1);
    // SE0 x8 is the longest accepted EOP
    add(LK,  1, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) add(LS0, 1, 0, 0, 0, 1);
    add(LJ,  1, 0, 1, 0, 1);
    // SE1 mid-packet
    add(LK,  1, 1, 0, 0, 1);
    add(LJ,  1, 1, 0, 0, 1);
    add(LS1, 1, 0, 0, 1, 2);
    add(LJ,  1, 0, 0, 0, 2);
    // rx_en gating and mid-packet drop
    add(LK,  0, 0, 0, 0, 2);
    add(LK,  1, 1, 0, 0, 2);
    add(LJ,  0, 0, 0, 0, 1);
    add(LS0, 1, 0, 0, 0, 1);
    add(LJ,  1, 0, 0, 0, 1);
    // babble: 129th bit aborts with count saturated at 128
    add(LK,  1, 1, 0, 0, 1);
    c = 1;
    for (int i = 2; i <= 128; i++) begin
      add((i % 2) ? LK : LJ, 1, 1, 0, 0, c);
      c++;
    end
    add(LK,  1, 0, 0, 1, 128);
    add(LJ,  1, 0, 0, 0, 128);

    rst_b = 1'b0; tx_start = 1'b0; tx_len = '0; tx_bit = 1'b0;
    rx_en = 1'b0; dp_r = 1'b1; dm_r = 1'b0;
    #1;
    chk("reset_tx", 32'(tx_outs()), 32'(5'b00010));
    chk("reset_rx", 32'({rx_valid, rx_done, rx_err}), 32'd0);
    chk("reset_cnt", 32'(rx_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;

    // 32-bit packet, alternating bits, with a K on the line that must stay gated
    @(negedge clk);
    tx_start = 1'b1; tx_len = 8'd32; tx_bit = 1'b0; rx_en = 1'b1;
    #1 chk("t1_start", 32'(tx_outs()), 32'(5'b00010));
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      tx_start = 1'b0;
      b = ((k - 1) % 2) == 1;
      tx_bit = b;
      {dp_r, dm_r} = (k <= 35) ? LK : LJ;
      #1;
      if (k <= 32)      chk($sformatf("t1_data%0d", k), 32'(tx_outs()), 32'({1'b1, 1'b1, 1'b0, b, ~b}));
      else if (k <= 34) chk($sformatf("t1_se0_%0d", k), 32'(tx_outs()), 32'(5'b01000));
      else if (k == 35) chk("t1_eopj", 32'(tx_outs()), 32'(5'b01110));
      else              chk("t1_idle", 32'(tx_outs()), 32'(5'b00010));
      chk($sformatf("t1_rxgate%0d", k), 32'(rx_valid), 32'd0);
    end

    // zero-length packet; second start while busy is dropped
    @(negedge clk);
    tx_start = 1'b1; tx_len = 8'd0;
    #1 chk("t2_start", 32'(tx_outs()), 32'(5'b00010));
    @(negedge clk); tx_len = 8'd5; #1 chk("t2_se0a", 32'(tx_outs()), 32'(5'b01000));
    @(negedge clk); tx_start = 1'b0; #1 chk("t2_se0b", 32'(tx_outs()), 32'(5'b01000));
    @(negedge clk); #1 chk("t2_eopj", 32'(tx_outs()), 32'(5'b01110));
    @(negedge clk); #1 chk("t2_idle", 32'(tx_outs()), 32'(5'b00010));

    // RX table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      dp_r = vecs[i].dp; dm_r = vecs[i].dm; rx_en = vecs[i].en;
      #1;
      chk($sformatf("rx%0d_flags", i), 32'({rx_valid, rx_done, rx_err}),
          32'({vecs[i].v, vecs[i].dn, vecs[i].er}));
      chk($sformatf("rx%0d_count", i), 32'(rx_count), 32'(vecs[i].cnt));
      if (vecs[i].v) chk($sformatf("rx%0d_bit", i), 32'(rx_bit), 32'(vecs[i].dp));
    end

    // oversized tx_len clamps to 128 data bits
    rx_en = 1'b0; dp_r = 1'b1; dm_r = 1'b0;
    @(negedge clk);
    tx_start = 1'b1; tx_len = 8'd200;
    reqs = 0; done_at = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      tx_start = 1'b0;
      #1;
      if (tx_bit_req) reqs++;
      if (tx_done) begin
        done_at = k;
        break;
      end
    end
    chk("clamp_reqs", 32'(reqs), 32'd128);
    chk("clamp_done_cycle", 32'(done_at), 32'd131);

    // reset in the middle of data drives J at once and clears rx_count
    @(negedge clk);
    tx_start = 1'b1; tx_len = 8'd10; tx_bit = 1'b0;
    @(negedge clk); tx_start = 1'b0;
    @(negedge clk);
    #1 chk("rst_mid_pre", 32'(tx_outs()), 32'(5'b11001));
    rst_b = 1'b0;
    #1;
    chk("rst_mid_tx", 32'(tx_outs()), 32'(5'b00010));
    chk("rst_mid_cnt", 32'(rx_count), 32'd0);
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk); #1 chk("rst_after", 32'(tx_outs()), 32'(5'b00010));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
